ahb_fifo_master_seq: RTL and testbench

- Synthesizable AHB-Lite master sequencer that drains the transaction FIFO and drives the bus.
- Each FIFO entry holds {write, size, addr, data}. The block issues one SINGLE NONSEQ transfer per entry and pipelines the address and data phases.
- It handles HREADY wait states and two-cycle HRESP errors, and returns read data to the requester.

---
 rtl/ahb_fifo_master_seq.sv | 191 +++++++++++++++++++
 tb/tb_ahb_fifo_master_seq.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_fifo_master_seq.sv
// rtl/ahb_fifo_master_seq.sv - AHB-Lite SINGLE-transfer master draining a FWFT transaction FIFO (optional MISALIGN_CHECK_EN)
module ahb_fifo_master_seq #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int HALT_ON_ERR = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic                  fifo_write,
    input  logic [2:0]            fifo_size,
    input  logic [ADDR_WIDTH-1:0] fifo_addr,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_pop,
    output logic [ADDR_WIDTH-1:0] HADDR,
    output logic                  HWRITE,
    output logic [2:0]            HSIZE,
    output logic [1:0]            HTRANS,
    output logic [2:0]            HBURST,
    output logic [DATA_WIDTH-1:0] HWDATA,
    input  logic [DATA_WIDTH-1:0] HRDATA,
    input  logic                  HREADY,
    input  logic                  HRESP,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  err,
    output logic                  illegal,
    output logic                  busy,
    output logic                  halted
);

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        ERR_WAIT = 2'd1,
        HALT     = 2'd2
    } state_t;

    state_t state, state_nx;

    // run_ok holds pops off for the first cycle after reset release
    logic                  run_ok;
    logic                  as_valid;
    logic [DATA_WIDTH-1:0] as_data;
    logic                  ds_valid;
    logic                  ds_write;
    logic [ADDR_WIDTH-1:0] ds_addr;
    logic                  rp_valid;
    logic                  rp_write;
    logic [2:0]            rp_size;
    logic [ADDR_WIDTH-1:0] rp_addr;
    logic [DATA_WIDTH-1:0] rp_data;
    logic                  entry_ok;
    logic                  err_first;
    logic                  err_last;
    logic                  issue_rp;
    logic                  issue_fifo;

    assign as_valid   = HTRANS[1];
    assign err_first  = (state == RUN) && ds_valid && HRESP && !HREADY;
    assign err_last   = (state == ERR_WAIT) && HRESP && HREADY;
    assign fifo_pop   = (state == RUN) && run_ok && enable && !fifo_empty && HREADY && !rp_valid;
    assign issue_rp   = (state == RUN) && rp_valid && HREADY;
    assign issue_fifo = fifo_pop && entry_ok;
    assign HBURST     = 3'b000;
    assign busy       = as_valid || ds_valid || rp_valid;
    assign halted     = (state == HALT);

`ifdef MISALIGN_CHECK_EN
    localparam int MAX_SIZE = $clog2(DATA_WIDTH / 8);

    logic [ADDR_WIDTH-1:0] low_mask;
    logic                  illegal_q;

    // Entry must fit the bus width and sit on its natural boundary
    always_comb begin
        low_mask = ~({ADDR_WIDTH{1'b1}} << fifo_size);
        entry_ok = (fifo_size <= 3'(MAX_SIZE)) && ((fifo_addr & low_mask) == '0);
    end

    // Flag an entry that was popped but dropped
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= fifo_pop && !entry_ok;
        end
    end

    assign illegal = illegal_q;
`else
    assign entry_ok = 1'b1;
    assign illegal  = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= state_nx;
        end
    end

    // FSM next state: error entry, error completion, leaving HALT on enable low
    always_comb begin
        state_nx = state;
        case (state)
            RUN:      if (err_first) state_nx = ERR_WAIT;
            ERR_WAIT: if (HRESP && HREADY) state_nx = (HALT_ON_ERR != 0) ? HALT : RUN;
            HALT:     if (!enable) state_nx = RUN;
            default:  state_nx = RUN;
        endcase
    end

    // Pipeline: address stage, data stage, replay capture and read return
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run_ok   <= 1'b0;
            HTRANS   <= TRANS_IDLE;
            HADDR    <= '0;
            HWRITE   <= 1'b0;
            HSIZE    <= 3'b000;
            HWDATA   <= '0;
            as_data  <= '0;
            ds_valid <= 1'b0;
            ds_write <= 1'b0;
            ds_addr  <= '0;
            rp_valid <= 1'b0;
            rp_write <= 1'b0;
            rp_size  <= 3'b000;
            rp_addr  <= '0;
            rp_data  <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
            rd_addr  <= '0;
            err      <= 1'b0;
        end else begin
            run_ok   <= 1'b1;
            rd_valid <= 1'b0;
            err      <= err_last;
            if (HREADY) begin
                ds_valid <= as_valid;
                if (as_valid) begin
                    ds_write <= HWRITE;
                    ds_addr  <= HADDR;
                    HWDATA   <= as_data;
                end
                if (ds_valid && !ds_write && !HRESP) begin
                    rd_valid <= 1'b1;
                    rd_data  <= HRDATA;
                    rd_addr  <= ds_addr;
                end
                if (issue_rp) begin
                    HTRANS   <= TRANS_NONSEQ;
                    HADDR    <= rp_addr;
                    HWRITE   <= rp_write;
                    HSIZE    <= rp_size;
                    as_data  <= rp_data;
                    rp_valid <= 1'b0;
                end else if (issue_fifo) begin
                    HTRANS   <= TRANS_NONSEQ;
                    HADDR    <= fifo_addr;
                    HWRITE   <= fifo_write;
                    HSIZE    <= fifo_size;
                    as_data  <= fifo_data;
                end else begin
                    HTRANS   <= TRANS_IDLE;
                end
            end else if (err_first) begin
                // The pending address phase is withdrawn and parked for reissue
                HTRANS <= TRANS_IDLE;
                if (as_valid) begin
                    rp_valid <= 1'b1;
                    rp_write <= HWRITE;
                    rp_size  <= HSIZE;
                    rp_addr  <= HADDR;
                    rp_data  <= as_data;
                end
            end
            if ((state == HALT) && !enable) begin
                rp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ahb_fifo_master_seq.sv
// tb/tb_ahb_fifo_master_seq.sv - directed table-driven bench for ahb_fifo_master_seq
module tb_ahb_fifo_master_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b1;
    logic [31:0] hrdata = '0;
    logic        hready = 1'b1;
    logic        hresp = 1'b0;
    logic        sel = 1'b0;

    logic        fifo_empty, fifo_write;
    logic [2:0]  fifo_size;
    logic [31:0] fifo_addr, fifo_data;

    logic        pop0, hwrite0, rdv0, err0, ill0, busy0, halt0;
    logic [31:0] haddr0, hwdata0, rdd0, rda0;
    logic [2:0]  hsize0, hburst0;
    logic [1:0]  htrans0;
    logic        pop1, hwrite1, rdv1, err1, ill1, busy1, halt1;
    logic [31:0] haddr1, hwdata1, rdd1, rda1;
    logic [2:0]  hsize1, hburst1;
    logic [1:0]  htrans1;

    logic        m_w [16];
    logic [2:0]  m_s [16];
    logic [31:0] m_a [16];
    logic [31:0] m_d [16];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    logic        pop_sel;

    int checks = 0;
    int fails = 0;

    always #5 clk = ~clk;

    assign fifo_empty = (rd_ptr == wr_ptr);
    assign fifo_write = m_w[rd_ptr[3:0]];
    assign fifo_size  = m_s[rd_ptr[3:0]];
    assign fifo_addr  = m_a[rd_ptr[3:0]];
    assign fifo_data  = m_d[rd_ptr[3:0]];
    assign pop_sel    = sel ? pop1 : pop0;

    always @(posedge clk) begin
        if (pop_sel) rd_ptr <= rd_ptr + 1;
    end

    ahb_fifo_master_seq #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .HALT_ON_ERR(0)) dut0 (
        .clk(clk), .reset(reset), .enable(enable), .fifo_empty(fifo_empty),
        .fifo_write(fifo_write), .fifo_size(fifo_size), .fifo_addr(fifo_addr),
        .fifo_data(fifo_data), .fifo_pop(pop0), .HADDR(haddr0), .HWRITE(hwrite0),
        .HSIZE(hsize0), .HTRANS(htrans0), .HBURST(hburst0), .HWDATA(hwdata0),
        .HRDATA(hrdata), .HREADY(hready), .HRESP(hresp), .rd_valid(rdv0),
        .rd_data(rdd0), .rd_addr(rda0), .err(err0), .illegal(ill0),
        .busy(busy0), .halted(halt0));

    ahb_fifo_master_seq #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .HALT_ON_ERR(1)) dut1 (
        .clk(clk), .reset(reset), .enable(enable), .fifo_empty(fifo_empty),
        .fifo_write(fifo_write), .fifo_size(fifo_size), .fifo_addr(fifo_addr),
        .fifo_data(fifo_data), .fifo_pop(pop1), .HADDR(haddr1), .HWRITE(hwrite1),
        .HSIZE(hsize1), .HTRANS(htrans1), .HBURST(hburst1), .HWDATA(hwdata1),
        .HRDATA(hrdata), .HREADY(hready), .HRESP(hresp), .rd_valid(rdv1),
        .rd_data(rdd1), .rd_addr(rda1), .err(err1), .illegal(ill1),
        .busy(busy1), .halted(halt1));

    typedef struct {
        logic        push;
        logic        pw;
        logic [31:0] pa;
        logic        hr;
        logic [31:0] hd;
        logic        e_pop;
        logic [1:0]  e_trans;
        logic        ca;
        logic [31:0] e_addr;
        logic        e_write;
        logic        cw;
        logic [31:0] e_wdata;
        logic        e_rdv;
        logic [31:0] e_rdata;
        logic [31:0] e_raddr;
        logic        e_busy;
    } vec_t;

    vec_t tbl [11];

    function automatic vec_t mk(logic push, logic pw, logic [31:0] pa, logic hr, logic [31:0] hd,
                                logic e_pop, logic [1:0] e_trans, logic ca, logic [31:0] e_addr,
                                logic e_write, logic cw, logic [31:0] e_wdata, logic e_rdv,
                                logic [31:0] e_rdata, logic [31:0] e_raddr, logic e_busy);
        vec_t v;
        v.push = push; v.pw = pw; v.pa = pa; v.hr = hr; v.hd = hd;
        v.e_pop = e_pop; v.e_trans = e_trans; v.ca = ca; v.e_addr = e_addr;
        v.e_write = e_write; v.cw = cw; v.e_wdata = e_wdata; v.e_rdv = e_rdv;
        v.e_rdata = e_rdata; v.e_raddr = e_raddr; v.e_busy = e_busy;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic w, input logic [2:0] s, input logic [31:0] a, input logic [31:0] d);
        m_w[wr_ptr[3:0]] = w;
        m_s[wr_ptr[3:0]] = s;
        m_a[wr_ptr[3:0]] = a;
        m_d[wr_ptr[3:0]] = d;
        wr_ptr++;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1; hready = 1'b1; hresp = 1'b0; enable = 1'b1; hrdata = '0;
        tick(); tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        // reset values
        #2;
        chk("rst htrans", 64'(htrans0), 64'd0);
        chk("rst haddr", 64'(haddr0), 64'd0);
        chk("rst hwdata", 64'(hwdata0), 64'd0);
        chk("rst hburst", 64'(hburst0), 64'd0);
        chk("rst pop", 64'(pop0), 64'd0);
        chk("rst busy", 64'(busy0), 64'd0);
        chk("rst flags", 64'({rdv0, err0, ill0, halt0}), 64'd0);
        chk("rst rd", 64'({rdd0, rda0}), 64'd0);
        do_reset();

        // write burst then a read with two wait states
        tbl[0]  = mk(0, 0, 0,     1, 0,          1, 2'b00, 0, 0,     0, 0, 0,     0, 0,          0,     0);
        tbl[1]  = mk(0, 0, 0,     1, 0,          1, 2'b10, 1, 32'h0, 1, 0, 0,     0, 0,          0,     1);
        tbl[2]  = mk(0, 0, 0,     1, 0,          1, 2'b10, 1, 32'h4, 1, 1, 'hA0, 0, 0,          0,     1);
        tbl[3]  = mk(0, 0, 0,     1, 0,          0, 2'b10, 1, 32'h8, 1, 1, 'hA1, 0, 0,          0,     1);
        tbl[4]  = mk(1, 0, 'h10,  1, 0,          1, 2'b00, 0, 0,     0, 1, 'hA2, 0, 0,          0,     1);
        tbl[5]  = mk(0, 0, 0,     1, 0,          0, 2'b10, 1, 'h10,  0, 1, 'hA2, 0, 0,          0,     1);
        tbl[6]  = mk(0, 0, 0,     0, 'h11111111, 0, 2'b00, 1, 'h10,  0, 0, 0,     0, 0,          0,     1);
        tbl[7]  = mk(0, 0, 0,     0, 'h22222222, 0, 2'b00, 1, 'h10,  0, 0, 0,     0, 0,          0,     1);
        tbl[8]  = mk(0, 0, 0,     1, 'hDEADBEEF, 0, 2'b00, 0, 0,     0, 0, 0,     0, 0,          0,     1);
        tbl[9]  = mk(0, 0, 0,     1, 'h33333333, 0, 2'b00, 0, 0,     0, 0, 0,     1, 'hDEADBEEF, 'h10,  0);
        tbl[10] = mk(0, 0, 0,     1, 'h44444444, 0, 2'b00, 0, 0,     0, 0, 0,     0, 0,          0,     0);
        sel = 1'b0;
        push(1, 3'b010, 32'h0, 32'hA0);
        push(1, 3'b010, 32'h4, 32'hA1);
        push(1, 3'b010, 32'h8, 32'hA2);
        for (int i = 0; i < 11; i++) begin
            if (tbl[i].push) push(tbl[i].pw, 3'b010, tbl[i].pa, 32'h0);
            hready = tbl[i].hr;
            hrdata = tbl[i].hd;
            @(negedge clk);
            chk($sformatf("v%0d pop", i), 64'(pop0), 64'(tbl[i].e_pop));
            chk($sformatf("v%0d htrans", i), 64'(htrans0), 64'(tbl[i].e_trans));
            if (tbl[i].ca) begin
                chk($sformatf("v%0d haddr", i), 64'(haddr0), 64'(tbl[i].e_addr));
                chk($sformatf("v%0d hwrite", i), 64'(hwrite0), 64'(tbl[i].e_write));
            end
            if (tbl[i].cw) chk($sformatf("v%0d hwdata", i), 64'(hwdata0), 64'(tbl[i].e_wdata));
            chk($sformatf("v%0d rd_valid", i), 64'(rdv0), 64'(tbl[i].e_rdv));
            if (tbl[i].e_rdv) begin
                chk($sformatf("v%0d rd_data", i), 64'(rdd0), 64'(tbl[i].e_rdata));
                chk($sformatf("v%0d rd_addr", i), 64'(rda0), 64'(tbl[i].e_raddr));
            end
            chk($sformatf("v%0d busy", i), 64'(busy0), 64'(tbl[i].e_busy));
            tick();
        end

        // error on write 0x20, read 0x24 replayed (no halt)
        do_reset();
        sel = 1'b0;
        push(1, 3'b010, 32'h20, 32'h55);
        push(0, 3'b010, 32'h24, 32'h0);
        @(negedge clk); chk("e0 pop", 64'(pop0), 64'd1); tick();
        @(negedge clk); chk("e1 haddr", 64'(haddr0), 64'h20); tick();
        hresp = 1'b1; hready = 1'b0;
        @(negedge clk); chk("e2 haddr", 64'(haddr0), 64'h24); chk("e2 pop", 64'(pop0), 64'd0); tick();
        hresp = 1'b1; hready = 1'b1;
        @(negedge clk); chk("e3 htrans", 64'(htrans0), 64'd0); chk("e3 busy", 64'(busy0), 64'd1); tick();
        hresp = 1'b0; hready = 1'b1;
        @(negedge clk); chk("e4 err", 64'(err0), 64'd1); chk("e4 halted", 64'(halt0), 64'd0); tick();
        @(negedge clk);
        chk("e5 err", 64'(err0), 64'd0);
        chk("e5 htrans", 64'(htrans0), 64'h2);
        chk("e5 haddr", 64'(haddr0), 64'h24);
        chk("e5 hwrite", 64'(hwrite0), 64'd0);
        tick();
        hrdata = 32'hCAFE0001;
        @(negedge clk); chk("e6 rd_valid", 64'(rdv0), 64'd0); tick();
        @(negedge clk);
        chk("e7 rd_valid", 64'(rdv0), 64'd1);
        chk("e7 rd_data", 64'(rdd0), 64'hCAFE0001);
        chk("e7 rd_addr", 64'(rda0), 64'h24);
        tick();

        // same error with halt-on-error
        do_reset();
        sel = 1'b1;
        push(1, 3'b010, 32'h20, 32'h55);
        push(0, 3'b010, 32'h24, 32'h0);
        push(1, 3'b010, 32'h30, 32'h66);
        @(negedge clk); chk("h0 pop", 64'(pop1), 64'd1); tick();
        @(negedge clk); chk("h1 pop", 64'(pop1), 64'd1); tick();
        hresp = 1'b1; hready = 1'b0;
        @(negedge clk); chk("h2 haddr", 64'(haddr1), 64'h24); tick();
        hresp = 1'b1; hready = 1'b1;
        @(negedge clk); chk("h3 htrans", 64'(htrans1), 64'd0); tick();
        hresp = 1'b0;
        @(negedge clk);
        chk("h4 err", 64'(err1), 64'd1);
        chk("h4 halted", 64'(halt1), 64'd1);
        chk("h4 pop", 64'(pop1), 64'd0);
        tick();
        enable = 1'b0;
        @(negedge clk);
        chk("h5 halted", 64'(halt1), 64'd1);
        chk("h5 htrans", 64'(htrans1), 64'd0);
        chk("h5 pop", 64'(pop1), 64'd0);
        tick();
        enable = 1'b1;
        @(negedge clk); chk("h6 halted", 64'(halt1), 64'd0); chk("h6 pop", 64'(pop1), 64'd1); tick();
        @(negedge clk);
        chk("h7 htrans", 64'(htrans1), 64'h2);
        chk("h7 haddr", 64'(haddr1), 64'h30);
        chk("h7 hwrite", 64'(hwrite1), 64'd1);
        tick();
        @(negedge clk); chk("h8 htrans", 64'(htrans1), 64'd0); tick();
        @(negedge clk); chk("h9 busy", 64'(busy1), 64'd0); tick();

        // async reset in a stalled write data phase
        do_reset();
        sel = 1'b0;
        push(1, 3'b010, 32'h40, 32'h77);
        @(negedge clk); chk("r0 pop", 64'(pop0), 64'd1); tick();
        @(negedge clk); chk("r1 haddr", 64'(haddr0), 64'h40); tick();
        hready = 1'b0;
        push(1, 3'b010, 32'h44, 32'h88);
        @(negedge clk); chk("r2 hwdata", 64'(hwdata0), 64'h77); chk("r2 pop", 64'(pop0), 64'd0);
        #1 reset = 1'b1;
        #1;
        chk("r3 htrans", 64'(htrans0), 64'd0);
        chk("r3 haddr", 64'(haddr0), 64'd0);
        chk("r3 hwdata", 64'(hwdata0), 64'd0);
        chk("r3 hwrite", 64'(hwrite0), 64'd0);
        chk("r3 busy", 64'(busy0), 64'd0);
        chk("r3 pop", 64'(pop0), 64'd0);
        tick();
        reset = 1'b0; hready = 1'b1;
        @(negedge clk); chk("r4 pop after release", 64'(pop0), 64'd0); tick();
        @(negedge clk); chk("r5 pop", 64'(pop0), 64'd1); tick();
        @(negedge clk); chk("r6 haddr", 64'(haddr0), 64'h44); tick();

        // misaligned word entry followed by an aligned one
        do_reset();
        sel = 1'b0;
        push(1, 3'b010, 32'h2, 32'h99);
        push(1, 3'b010, 32'h4, 32'h9A);
        @(negedge clk); chk("m0 pop", 64'(pop0), 64'd1); tick();
`ifdef MISALIGN_CHECK_EN
        @(negedge clk);
        chk("m1 illegal", 64'(ill0), 64'd1);
        chk("m1 htrans", 64'(htrans0), 64'd0);
        chk("m1 pop", 64'(pop0), 64'd1);
        tick();
`else
        @(negedge clk);
        chk("m1 illegal", 64'(ill0), 64'd0);
        chk("m1 htrans", 64'(htrans0), 64'h2);
        chk("m1 haddr", 64'(haddr0), 64'h2);
        tick();
`endif
        @(negedge clk);
        chk("m2 illegal", 64'(ill0), 64'd0);
        chk("m2 htrans", 64'(htrans0), 64'h2);
        chk("m2 haddr", 64'(haddr0), 64'h4);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
